// File: rtl/pc_stack.sv
// Fetch-stage program counter with branch/jump/stop, call/return through a
// circular return-address stack, fetch stall and a resumable HALT state.
module pc_stack #(
   parameter int unsigned WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int unsigned RAS_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         stall,
   input  logic [2:0]                   pc_op,
   input  logic                         branch_taken,
   input  logic [WIDTH-1:0]             abs_addr,
   input  logic [WIDTH-1:0]             branch_off,
   input  logic                         resume,
   output logic [WIDTH-1:0]             current_pc,
   output logic                         halted,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_overflow,
   output logic                         ras_underflow
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [2:0] OP_NORMAL = 3'b000;
   localparam logic [2:0] OP_BRANCH = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_STOP   = 3'b011;
   localparam logic [2:0] OP_CALL   = 3'b100;
   localparam logic [2:0] OP_RET    = 3'b101;

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   pc_q, pc_d;
   logic [PW-1:0]      top_q, top_d;
   logic [CW-1:0]      count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;

   logic [WIDTH-1:0]   ras_mem [RAS_DEPTH];
   logic               push_en;
   logic [WIDTH-1:0]   push_data;
   logic [PW-1:0]      top_prev;
   logic [WIDTH-1:0]   pc_inc;
   logic               ras_full;
   logic               ras_empty;

   assign top_prev  = top_q - PW'(1);
   assign pc_inc    = pc_q + WIDTH'(1);
   assign ras_full  = (count_q == CW'(RAS_DEPTH));
   assign ras_empty = (count_q == '0);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      top_d     = top_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      push_en   = 1'b0;
      push_data = pc_inc;

      if (state_q == HALT) begin
         if (resume) begin
            pc_d    = pc_inc;
            state_d = RUN;
         end
      end else begin
         unique case (pc_op)
            OP_NORMAL: pc_d = pc_inc;
            OP_BRANCH: pc_d = branch_taken ? (pc_inc + branch_off) : pc_inc;
            OP_JUMP:   pc_d = abs_addr;
            OP_STOP:   state_d = HALT;
            OP_CALL: begin
               // A full stack overwrites the oldest slot, which is the one at top.
               pc_d    = abs_addr;
               push_en = 1'b1;
               top_d   = top_q + PW'(1);
               if (ras_full) ovf_d = 1'b1;
               else          count_d = count_q + CW'(1);
            end
            OP_RET: begin
               if (ras_empty) begin
                  pc_d  = pc_inc;
                  unf_d = 1'b1;
               end else begin
                  pc_d    = ras_mem[top_prev];
                  top_d   = top_prev;
                  count_d = count_q - CW'(1);
               end
            end
            default: pc_d = pc_q;
         endcase
      end
   end

   always_ff @(negedge clk) begin
      if (clr) begin
         state_q <= RUN;
         pc_q    <= RESET_VEC;
         top_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (!stall) begin
         state_q <= state_d;
         pc_q    <= pc_d;
         top_q   <= top_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack storage carries no reset; contents are meaningless once count is zero.
   always_ff @(negedge clk) begin
      if (!clr && !stall && push_en) ras_mem[top_q] <= push_data;
   end

   assign current_pc    = pc_q;
   assign halted        = (state_q == HALT);
   assign ras_count     = count_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;

endmodule
